// File: rtl/arbitro_fifo.sv
// arbitro_fifo: round-robin pop scheduler merging NF upstream FIFOs into
// one downstream stream.
//   clk, reset            : single clock, synchronous active-high reset
//   init                  : hold in INIT and load the shared thresholds
//   umbral_af_in/ae_in    : thresholds to distribute to every FIFO
//   fifo_empty            : per-FIFO empty flag
//   almost_full           : per-FIFO almost-full flag (priority request)
//   valid_in, data_in     : per-FIFO returned word, FIFO i on [i*DW +: DW]
//   out_almost_full       : downstream backpressure, blocks new pops
//   pop                   : registered one-hot pop
//   umbral_almost_full/_empty : registered thresholds
//   out_push, out_data    : registered push/word to the downstream FIFO
//   state, idle           : 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE; idle = IDLE
//   error                 : sticky protocol error
module arbitro_fifo #(
   parameter int NF = 4,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            init,
   input  logic [3:0]      umbral_af_in,
   input  logic [3:0]      umbral_ae_in,
   input  logic [NF-1:0]   fifo_empty,
   input  logic [NF-1:0]   almost_full,
   input  logic [NF-1:0]   valid_in,
   input  logic [NF*DW-1:0] data_in,
   input  logic            out_almost_full,
   output logic [NF-1:0]   pop,
   output logic [3:0]      umbral_almost_full,
   output logic [3:0]      umbral_almost_empty,
   output logic            out_push,
   output logic [DW-1:0]   out_data,
   output logic [1:0]      state,
   output logic            idle,
   output logic            error
);

   localparam int RW = (NF > 1) ? $clog2(NF) : 1;

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} st_t;

   st_t           st;
   logic [RW-1:0] rr;
   logic [NF-1:0] pop_q;   // pop driven this cycle
   logic [NF-1:0] pop_d1;  // pop of last cycle: its word is on data_in now
   logic [NF-1:0] elig, cls, gnt;
   logic [RW-1:0] gidx;
   logic          gvalid, do_grant;
   logic [DW-1:0] word;
   logic          got, miss, stray;
   int            sel;

   // A FIFO popped this cycle is excluded so its registered empty flag has
   // caught up before it can be popped again.
   always_comb begin
      elig   = ~fifo_empty & ~pop_q;
      cls    = (|(elig & almost_full)) ? (elig & almost_full) : elig;
      gnt    = '0;
      gidx   = '0;
      gvalid = 1'b0;
      sel    = 0;
      for (int k = 0; k < NF; k++) begin
         sel = int'(rr) + k;
         if (sel >= NF) sel = sel - NF;
         if (!gvalid && cls[sel]) begin
            gvalid    = 1'b1;
            gnt[sel]  = 1'b1;
            gidx      = RW'(sel);
         end
      end
   end

   assign do_grant = (st == ST_ACTIVE) && !init && !out_almost_full && gvalid;

   always_comb begin
      word = '0;
      for (int i = 0; i < NF; i++)
         if (pop_d1[i]) word = data_in[i*DW +: DW];
   end

   assign got   = |(valid_in & pop_d1);
   assign miss  = (|pop_d1) && !got;
   assign stray = |(valid_in & ~pop_d1);

   always_ff @(posedge clk) begin
      if (reset) begin
         st                  <= ST_RESET;
         rr                  <= '0;
         pop_q               <= '0;
         pop_d1              <= '0;
         umbral_almost_full  <= '0;
         umbral_almost_empty <= '0;
         out_push            <= 1'b0;
         out_data            <= '0;
         error               <= 1'b0;
      end else begin
         pop_d1   <= pop_q;
         pop_q    <= do_grant ? gnt : '0;
         if (do_grant)
            rr <= (gidx == RW'(NF-1)) ? '0 : gidx + 1'b1;
         // In-flight words are still forwarded regardless of state.
         out_push <= got;
         if (got) out_data <= word;
         if (miss || stray) error <= 1'b1;
         case (st)
            ST_RESET: st <= ST_INIT;
            ST_INIT: begin
               if (init) begin
                  umbral_almost_full  <= umbral_af_in;
                  umbral_almost_empty <= umbral_ae_in;
               end else begin
                  st <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (init)              st <= ST_INIT;
               else if (|(~fifo_empty)) st <= ST_ACTIVE;
            end
            default: begin
               if (init) st <= ST_INIT;
               else if ((&fifo_empty) && (pop_q == '0) && (pop_d1 == '0))
                  st <= ST_IDLE;
            end
         endcase
      end
   end

   assign pop   = pop_q;
   assign state = st;
   assign idle  = (st == ST_IDLE);

endmodule
